// File: rtl/seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed hex display scanner for NUM_DIGITS 7-segment digits.
//   Each digit gets a slot of SCAN_DIV clocks. The first GUARD clocks of every
//   slot keep all anodes off to avoid ghosting. Within a slot, the low PWM_BITS
//   of the slot counter form a PWM period that sets the brightness. New data is
//   held in a pending buffer and moved to the display only at the frame
//   boundary, so a frame never mixes old and new digits.
//
// Ports
//   clk          system clock
//   clr_n        synchronous active-low reset
//   i_data       hex nibbles, digit k = i_data[4k+3:4k], digit 0 rightmost
//   i_dp         decimal point per digit (1 = lit)
//   i_load       one-cycle strobe that captures i_data / i_dp
//   i_digit_en   per-digit enable mask (1 = digit may be lit)
//   i_blank_lz   1 = suppress leading zeros
//   i_brightness on-time per PWM period, 0 = dark
//   a_to_g       segment drive, bit order gfedcba
//   an           anode selects
//   dp           decimal point drive
//   o_digit_idx  digit slot currently driven
//   o_frame_done one-cycle pulse after the last slot of each frame
//------------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 262144,
   parameter int PWM_BITS   = 4,
   parameter int GUARD      = 2,
   parameter int ACTIVE_LOW = 1,
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                      clk,
   input  logic                      clr_n,
   input  logic [4*NUM_DIGITS-1:0]   i_data,
   input  logic [NUM_DIGITS-1:0]     i_dp,
   input  logic                      i_load,
   input  logic [NUM_DIGITS-1:0]     i_digit_en,
   input  logic                      i_blank_lz,
   input  logic [PWM_BITS-1:0]       i_brightness,
   output logic [6:0]                a_to_g,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      dp,
   output logic [IDX_W-1:0]          o_digit_idx,
   output logic                      o_frame_done
);

   localparam int                 DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0]   GUARD_V  = DIV_W'(GUARD);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   // XOR mask that turns internal active-high drive into pin polarity
   localparam logic               POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   // Active-low gfedcba glyph for a hex nibble
   function automatic logic [6:0] glyph_lo(input logic [3:0] nib);
      case (nib)
         4'h0:    glyph_lo = 7'h40;
         4'h1:    glyph_lo = 7'h79;
         4'h2:    glyph_lo = 7'h24;
         4'h3:    glyph_lo = 7'h30;
         4'h4:    glyph_lo = 7'h19;
         4'h5:    glyph_lo = 7'h12;
         4'h6:    glyph_lo = 7'h02;
         4'h7:    glyph_lo = 7'h78;
         4'h8:    glyph_lo = 7'h00;
         4'h9:    glyph_lo = 7'h10;
         4'hA:    glyph_lo = 7'h08;
         4'hB:    glyph_lo = 7'h03;
         4'hC:    glyph_lo = 7'h27;
         4'hD:    glyph_lo = 7'h21;
         4'hE:    glyph_lo = 7'h06;
         4'hF:    glyph_lo = 7'h0E;
         default: glyph_lo = 7'h7F;
      endcase
   endfunction

   logic [DIV_W-1:0]          div_r;
   logic [IDX_W-1:0]          idx_r;
   logic [4*NUM_DIGITS-1:0]   disp_data_r;
   logic [NUM_DIGITS-1:0]     disp_dp_r;
   logic [4*NUM_DIGITS-1:0]   pend_data_r;
   logic [NUM_DIGITS-1:0]     pend_dp_r;
   logic                      pend_valid_r;

   logic                      boundary_s;
   logic [NUM_DIGITS-1:0]     blank_s;
   logic [3:0]                cur_nib_s;
   logic                      lit_s;
   logic [NUM_DIGITS-1:0]     an_hi_s;
   logic [6:0]                seg_hi_s;
   logic                      dp_hi_s;

   // Frame boundary: last clock of the last digit slot
   always_comb begin
      boundary_s = (div_r == DIV_LAST) && (idx_r == IDX_LAST);
   end

   // Leading-zero mask: walk down from the top digit while nibbles are zero
   always_comb begin
      logic zero_run;
      blank_s  = '0;
      zero_run = i_blank_lz;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (zero_run && (disp_data_r[4*k +: 4] == 4'h0)) begin
            blank_s[k] = 1'b1;
         end else begin
            zero_run = 1'b0;
         end
      end
   end

   // Lit decision for the current slot: enable, not blanked, past guard, PWM on
   always_comb begin
      cur_nib_s = disp_data_r[{idx_r, 2'b00} +: 4];
      lit_s     = i_digit_en[idx_r] & ~blank_s[idx_r] &
                  (div_r >= GUARD_V) &
                  (div_r[PWM_BITS-1:0] < i_brightness);
   end

   // Active-high drive for the next output cycle
   always_comb begin
      an_hi_s  = '0;
      seg_hi_s = 7'h00;
      dp_hi_s  = 1'b0;
      if (lit_s) begin
         an_hi_s[idx_r] = 1'b1;
         seg_hi_s       = ~glyph_lo(cur_nib_s);
         dp_hi_s        = disp_dp_r[idx_r];
      end else begin
         an_hi_s  = '0;
         seg_hi_s = 7'h00;
         dp_hi_s  = 1'b0;
      end
   end

   // Slot divider and digit index
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         div_r <= '0;
         idx_r <= '0;
      end else if (div_r == DIV_LAST) begin
         div_r <= '0;
         if (idx_r == IDX_LAST) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Pending buffer and frame-synchronous display update
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         disp_data_r  <= '0;
         disp_dp_r    <= '0;
         pend_data_r  <= '0;
         pend_dp_r    <= '0;
         pend_valid_r <= 1'b0;
      end else if (boundary_s && i_load) begin
         // A load on the boundary edge bypasses the pending buffer
         disp_data_r  <= i_data;
         disp_dp_r    <= i_dp;
         pend_valid_r <= 1'b0;
      end else if (boundary_s && pend_valid_r) begin
         disp_data_r  <= pend_data_r;
         disp_dp_r    <= pend_dp_r;
         pend_valid_r <= 1'b0;
      end else if (i_load) begin
         pend_data_r  <= i_data;
         pend_dp_r    <= i_dp;
         pend_valid_r <= 1'b1;
      end else begin
         pend_valid_r <= pend_valid_r;
      end
   end

   // Registered pin drive and status outputs
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         a_to_g       <= {7{POL}};
         an           <= {NUM_DIGITS{POL}};
         dp           <= POL;
         o_digit_idx  <= '0;
         o_frame_done <= 1'b0;
      end else begin
         a_to_g       <= seg_hi_s ^ {7{POL}};
         an           <= an_hi_s ^ {NUM_DIGITS{POL}};
         dp           <= dp_hi_s ^ POL;
         o_digit_idx  <= idx_r;
         o_frame_done <= boundary_s;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Directed bench for seg7_scan_ctrl with 4 digits, 16-clock slots, 2-bit PWM.
//   A cycle-count model derives slot/digit from elapsed clocks and predicts
//   every output each cycle; directed steps add hand-computed expectations.
//------------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   localparam int ND = 4;
   localparam int SD = 16;
   localparam int PB = 2;
   localparam int GD = 2;

   logic          clk = 1'b0;
   logic          clr_n;
   logic [15:0]   i_data;
   logic [3:0]    i_dp;
   logic          i_load;
   logic [3:0]    i_digit_en;
   logic          i_blank_lz;
   logic [1:0]    i_brightness;
   logic [6:0]    a_to_g;
   logic [3:0]    an;
   logic          dp;
   logic [1:0]    o_digit_idx;
   logic          o_frame_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .PWM_BITS   (PB),
      .GUARD      (GD),
      .ACTIVE_LOW (1)
   ) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .i_data       (i_data),
      .i_dp         (i_dp),
      .i_load       (i_load),
      .i_digit_en   (i_digit_en),
      .i_blank_lz   (i_blank_lz),
      .i_brightness (i_brightness),
      .a_to_g       (a_to_g),
      .an           (an),
      .dp           (dp),
      .o_digit_idx  (o_digit_idx),
      .o_frame_done (o_frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
   int          m_t;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_dpd, m_pdp;
   logic        m_pv;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [1:0]  e_idx;
   logic        e_fd;
   logic        chk_en = 1'b0;

   // Model: slot and digit come from elapsed clocks since reset release
   always @(posedge clk) begin : model
      int  dv, ix, hi, nib;
      bit  lit, bnd;
      if (!clr_n) begin
         m_t    <= 0;
         m_disp <= 16'h0;  m_dpd <= 4'h0;
         m_pend <= 16'h0;  m_pdp <= 4'h0;  m_pv <= 1'b0;
         e_an   <= 4'hF;   e_seg <= 7'h7F; e_dp <= 1'b1;
         e_idx  <= 2'd0;   e_fd  <= 1'b0;
         chk_en <= 1'b1;
      end else begin
         dv  = m_t % SD;
         ix  = (m_t / SD) % ND;
         bnd = (dv == SD - 1) && (ix == ND - 1);
         hi  = 0;
         for (int k = 0; k < ND; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
         lit = i_digit_en[ix] && !(i_blank_lz && ix > hi) && (dv >= GD) &&
               ((dv % (1 << PB)) < int'(i_brightness));
         nib = int'(m_disp[4*ix +: 4]);
         e_an  <= lit ? ~(4'b0001 << ix) : 4'hF;
         e_seg <= lit ? glyph_tab[nib] : 7'h7F;
         e_dp  <= lit ? ~m_dpd[ix] : 1'b1;
         e_idx <= 2'(ix);
         e_fd  <= bnd;
         if (bnd && i_load) begin
            m_disp <= i_data; m_dpd <= i_dp; m_pv <= 1'b0;
         end else if (bnd && m_pv) begin
            m_disp <= m_pend; m_dpd <= m_pdp; m_pv <= 1'b0;
         end else if (i_load) begin
            m_pend <= i_data; m_pdp <= i_dp; m_pv <= 1'b1;
         end
         m_t <= m_t + 1;
      end
   end

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("an",         32'(an),           32'(e_an));
         check("a_to_g",     32'(a_to_g),       32'(e_seg));
         check("dp",         32'(dp),           32'(e_dp));
         check("digit_idx",  32'(o_digit_idx),  32'(e_idx));
         check("frame_done", 32'(o_frame_done), 32'(e_fd));
      end
   end

   // ---------------- directed stimulus ----------------
   logic [6:0] obs_seg  [ND];
   logic       obs_dp   [ND];
   bit         obs_seen [ND];
   int         lit_cnt;

   task automatic load(input logic [15:0] d, input logic [3:0] p);
      i_data = d; i_dp = p; i_load = 1'b1;
      @(negedge clk);
      i_load = 1'b0;
   endtask

   task automatic wait_fd();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_frame_done !== 1'b1 && n < 200);
      check("wait_frame_done", 32'(o_frame_done), 32'd1);
   endtask

   // Sample n consecutive negedges starting at the current one
   task automatic observe_n(input int n);
      for (int k = 0; k < ND; k++) begin
         obs_seen[k] = 1'b0; obs_seg[k] = 7'h7F; obs_dp[k] = 1'b1;
      end
      lit_cnt = 0;
      for (int c = 0; c < n; c++) begin
         if (an != 4'hF) begin
            check("an_onehot", 32'($countones(~an)), 32'd1);
            lit_cnt++;
            for (int k = 0; k < ND; k++) begin
               if (!an[k]) begin
                  obs_seen[k] = 1'b1; obs_seg[k] = a_to_g; obs_dp[k] = dp;
               end
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      clr_n = 1'b0; i_data = 16'h0; i_dp = 4'h0; i_load = 1'b0;
      i_digit_en = 4'hF; i_blank_lz = 1'b0; i_brightness = 2'd3;

      // Reset held three cycles
      repeat (3) @(negedge clk);
      check("rst_an",  32'(an),     32'hF);
      check("rst_seg", 32'(a_to_g), 32'h7F);
      check("rst_dp",  32'(dp),     32'd1);
      clr_n = 1'b1;
      repeat (2) @(negedge clk);
      check("guard_an", 32'(an), 32'hF);
      @(negedge clk);
      check("first_an",  32'(an),     32'hE);
      check("first_seg", 32'(a_to_g), 32'h40);

      // Normal load, shown from the next frame
      load(16'h12AF, 4'b0100);
      wait_fd();
      observe_n(64);
      check("d0_seg", 32'(obs_seg[0]), 32'h0E);
      check("d1_seg", 32'(obs_seg[1]), 32'h08);
      check("d2_seg", 32'(obs_seg[2]), 32'h24);
      check("d2_dp",  32'(obs_dp[2]),  32'd0);
      check("d0_dp",  32'(obs_dp[0]),  32'd1);
      check("d3_seg", 32'(obs_seg[3]), 32'h79);
      check("fd_period", 32'(o_frame_done), 32'd1);

      // Mid-frame load at digit 1: rest of the frame keeps old data
      repeat (20) @(negedge clk);
      load(16'h0000, 4'h0);
      observe_n(43);
      check("mid_d2_old", 32'(obs_seg[2]), 32'h24);
      check("mid_d3_old", 32'(obs_seg[3]), 32'h79);
      check("mid_fd",     32'(o_frame_done), 32'd1);
      observe_n(64);
      check("mid_d0_new", 32'(obs_seg[0]), 32'h40);
      check("mid_d3_new", 32'(obs_seg[3]), 32'h40);
      check("mid_d2_dp",  32'(obs_dp[2]),  32'd1);

      // Pending 9999 overridden by a load on the boundary edge
      repeat (10) @(negedge clk);
      load(16'h9999, 4'hF);
      repeat (52) @(negedge clk);
      load(16'h5555, 4'h0);
      check("bnd_load_fd", 32'(o_frame_done), 32'd1);
      observe_n(64);
      check("bnd_d0", 32'(obs_seg[0]), 32'h12);
      check("bnd_d3", 32'(obs_seg[3]), 32'h12);
      observe_n(64);
      check("nostale_d0", 32'(obs_seg[0]), 32'h12);
      check("nostale_d2", 32'(obs_seg[2]), 32'h12);

      // Leading-zero suppression
      i_blank_lz = 1'b1;
      load(16'h0030, 4'hF);
      wait_fd();
      observe_n(64);
      check("lz_d3_dark", 32'(obs_seen[3]), 32'd0);
      check("lz_d2_dark", 32'(obs_seen[2]), 32'd0);
      check("lz_d1_seg",  32'(obs_seg[1]),  32'h30);
      check("lz_d1_dp",   32'(obs_dp[1]),   32'd0);
      check("lz_d0_seg",  32'(obs_seg[0]),  32'h40);
      load(16'h0000, 4'hF);
      wait_fd();
      observe_n(64);
      check("lz0_d1_dark", 32'(obs_seen[1]), 32'd0);
      check("lz0_d3_dark", 32'(obs_seen[3]), 32'd0);
      check("lz0_d0_seg",  32'(obs_seg[0]),  32'h40);
      i_blank_lz = 1'b0;

      // Brightness and enable mask
      i_brightness = 2'd1;
      observe_n(64);
      check("bright1_cnt", 32'(lit_cnt), 32'd12);
      i_brightness = 2'd0;
      observe_n(64);
      check("bright0_cnt", 32'(lit_cnt), 32'd0);
      i_brightness = 2'd3;
      i_digit_en   = 4'b1011;
      observe_n(64);
      check("en_d2_dark", 32'(obs_seen[2]), 32'd0);
      check("en_cnt",     32'(lit_cnt),     32'd30);
      i_digit_en = 4'hF;

      // Reset mid-slot discards pending data
      repeat (5) @(negedge clk);
      load(16'h8888, 4'h0);
      check("pre_rst_an", 32'(an), 32'hE);
      clr_n = 1'b0;
      @(negedge clk);
      check("mrst_an",  32'(an),           32'hF);
      check("mrst_seg", 32'(a_to_g),       32'h7F);
      check("mrst_dp",  32'(dp),           32'd1);
      check("mrst_idx", 32'(o_digit_idx),  32'd0);
      check("mrst_fd",  32'(o_frame_done), 32'd0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      wait_fd();
      observe_n(64);
      check("post_rst_d0", 32'(obs_seg[0]), 32'h40);
      check("post_rst_d3", 32'(obs_seg[3]), 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
